// File: rtl/keypad_entry_if.sv
// Keypad matrix lines plus the decoded key/operand outputs of keypad_entry.
interface keypad_entry_if;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [31:0] entry;
    logic [3:0]  digit_count;
    logic [31:0] result;
    logic        result_valid;

    modport master (
        input  rows,
        output cols, key_strobe, key_code, entry, digit_count, result, result_valid
    );

    modport slave (
        output rows,
        input  cols, key_strobe, key_code, entry, digit_count, result, result_valid
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and decimal-to-binary operand entry.
//   state      | meaning
//   S_SCAN     | drive one column per divider period, sample rows at terminal count
//   S_DEBOUNCE | captured row pattern must stay identical for DEBOUNCE cycles
//   S_HELD     | key accepted; wait for DEBOUNCE consecutive released cycles
module keypad_entry #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 200000,
    parameter int MAX_DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    keypad_entry_if.master kp
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

    state_t            state, state_n;
    logic [1:0]        col, col_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [DB_W-1:0]   cnt, cnt_n;
    logic [3:0]        pat, pat_n;
    logic              strobe, strobe_n;
    logic [3:0]        code, code_n;
    logic [31:0]       entry, entry_n;
    logic [3:0]        count, count_n;
    logic [31:0]       result, result_n;
    logic              rv, rv_n;

    // Lowest-index low row wins when several rows are pulled low.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    logic [3:0] key;
    assign key = map_key(low_row(pat), col);

    always_comb begin
        state_n  = state;
        col_n    = col;
        div_n    = div;
        cnt_n    = cnt;
        pat_n    = pat;
        strobe_n = 1'b0;
        code_n   = code;
        entry_n  = entry;
        count_n  = count;
        result_n = result;
        rv_n     = 1'b0;
        case (state)
            S_SCAN: begin
                if (div == '0) begin
                    if (kp.rows == 4'hF) begin
                        col_n = col + 2'd1;
                        div_n = DIV_LOAD;
                    end else begin
                        pat_n   = kp.rows;
                        cnt_n   = DB_LOAD;
                        state_n = S_DEBOUNCE;
                    end
                end else begin
                    div_n = div - 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (kp.rows != pat) begin
                    state_n = S_SCAN;
                    col_n   = col + 2'd1;
                    div_n   = DIV_LOAD;
                end else if (cnt == '0) begin
                    state_n  = S_HELD;
                    cnt_n    = DB_LOAD;
                    strobe_n = 1'b1;
                    code_n   = key;
                    if (key <= 4'd9) begin
                        if (count < 4'(MAX_DIGITS)) begin
                            entry_n = (entry << 3) + (entry << 1) + {28'd0, key};
                            count_n = count + 4'd1;
                        end
                    end else if (key == 4'hE) begin
                        entry_n = '0;
                        count_n = '0;
                    end else if (key == 4'hF) begin
                        result_n = entry;
                        rv_n     = 1'b1;
                        entry_n  = '0;
                        count_n  = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_HELD: begin
                if (kp.rows != 4'hF) begin
                    cnt_n = DB_LOAD;
                end else if (cnt == '0) begin
                    state_n = S_SCAN;
                    col_n   = col + 2'd1;
                    div_n   = DIV_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_SCAN;
            col    <= 2'd0;
            div    <= DIV_LOAD;
            cnt    <= '0;
            pat    <= 4'hF;
            strobe <= 1'b0;
            code   <= 4'h0;
            entry  <= '0;
            count  <= '0;
            result <= '0;
            rv     <= 1'b0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            div    <= div_n;
            cnt    <= cnt_n;
            pat    <= pat_n;
            strobe <= strobe_n;
            code   <= code_n;
            entry  <= entry_n;
            count  <= count_n;
            result <= result_n;
            rv     <= rv_n;
        end
    end

    assign kp.cols         = ~(4'b0001 << col);
    assign kp.key_strobe   = strobe;
    assign kp.key_code     = code;
    assign kp.entry        = entry;
    assign kp.digit_count  = count;
    assign kp.result       = result;
    assign kp.result_valid = rv;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a simple keypad matrix model driving rows.
module tb_keypad_entry;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_entry_if kp ();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(8), .MAX_DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    logic       key_down = 1'b0;
    logic [1:0] kr = 2'd0;
    logic [1:0] kc = 2'd0;

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        kp.rows = 4'hF;
        if (key_down && kp.cols[kc] == 1'b0) kp.rows[kr] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_rv = 0;

    always @(negedge clk) begin
        if (kp.key_strobe)   n_strobe <= n_strobe + 1;
        if (kp.result_valid) n_rv     <= n_rv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (kp.key_strobe) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] exp_code,
                         output logic rv_at);
        kr = r;
        kc = c;
        key_down = 1'b1;
        wait_strobe("strobe_seen");
        chk("key_code", {28'd0, kp.key_code}, {28'd0, exp_code});
        rv_at = kp.result_valid;
        cyc(5);
        key_down = 1'b0;
        cyc(12);
    endtask

    logic       rv_at;
    int         s0, r0;
    logic [3:0] ecol;

    initial begin
        // Reset and idle column rotation
        cyc(2);
        chk("rst_cols", {28'd0, kp.cols}, 32'hE);
        chk("rst_strobe", {31'd0, kp.key_strobe}, 32'd0);
        chk("rst_code", {28'd0, kp.key_code}, 32'd0);
        chk("rst_entry", kp.entry, 32'd0);
        chk("rst_count", {28'd0, kp.digit_count}, 32'd0);
        chk("rst_result", kp.result, 32'd0);
        chk("rst_rv", {31'd0, kp.result_valid}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ecol = ~(4'b0001 << ((k / 4) % 4));
            chk("idle_cols", {28'd0, kp.cols}, {28'd0, ecol});
        end
        chk("idle_strobes", 32'(n_strobe), 32'd0);
        chk("idle_entry", kp.entry, 32'd0);

        // '5' pressed out of reset: sampled at edge 8, strobe after edge 16
        rst = 1'b1;
        kr = 2'd1;
        kc = 2'd1;
        key_down = 1'b1;
        cyc(2);
        rst = 1'b0;
        s0 = n_strobe;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 12) chk("deb_cols_hold", {28'd0, kp.cols}, 32'hD);
            if (k == 15) chk("lat_early", {31'd0, kp.key_strobe}, 32'd0);
            if (k == 16) begin
                chk("lat_strobe", {31'd0, kp.key_strobe}, 32'd1);
                chk("p5_code", {28'd0, kp.key_code}, 32'd5);
                chk("p5_entry", kp.entry, 32'd5);
                chk("p5_count", {28'd0, kp.digit_count}, 32'd1);
            end
        end
        cyc(14);
        key_down = 1'b0;
        cyc(12);
        chk("p5_one_strobe", 32'(n_strobe - s0), 32'd1);

        // Clear, then 1 2 3 4 5 #
        press(2'd3, 2'd0, 4'hE, rv_at);
        chk("star_entry", kp.entry, 32'd0);
        chk("star_count", {28'd0, kp.digit_count}, 32'd0);
        press(2'd0, 2'd0, 4'h1, rv_at);
        press(2'd0, 2'd1, 4'h2, rv_at);
        press(2'd0, 2'd2, 4'h3, rv_at);
        press(2'd1, 2'd0, 4'h4, rv_at);
        chk("e1234_entry", kp.entry, 32'd1234);
        chk("e1234_count", {28'd0, kp.digit_count}, 32'd4);
        s0 = n_strobe;
        press(2'd1, 2'd1, 4'h5, rv_at);
        chk("fifth_strobe", 32'(n_strobe - s0), 32'd1);
        chk("fifth_entry", kp.entry, 32'd1234);
        chk("fifth_count", {28'd0, kp.digit_count}, 32'd4);
        r0 = n_rv;
        press(2'd3, 2'd2, 4'hF, rv_at);
        chk("hash_rv_with_strobe", {31'd0, rv_at}, 32'd1);
        chk("hash_rv_once", 32'(n_rv - r0), 32'd1);
        chk("hash_result", kp.result, 32'd1234);
        chk("hash_entry", kp.entry, 32'd0);
        chk("hash_count", {28'd0, kp.digit_count}, 32'd0);

        // Bouncing '7'
        kr = 2'd2;
        kc = 2'd0;
        s0 = n_strobe;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) key_down = ~key_down;
            @(negedge clk);
        end
        chk("bounce_no_strobe", 32'(n_strobe - s0), 32'd0);
        wait_strobe("bounce_strobe_seen");
        chk("bounce_code", {28'd0, kp.key_code}, 32'd7);
        chk("bounce_entry", kp.entry, 32'd7);
        cyc(5);
        key_down = 1'b0;
        cyc(12);
        chk("bounce_one_strobe", 32'(n_strobe - s0), 32'd1);
        press(2'd3, 2'd0, 4'hE, rv_at);

        // 9 8 * 7 #
        press(2'd2, 2'd2, 4'h9, rv_at);
        press(2'd2, 2'd1, 4'h8, rv_at);
        chk("e98_entry", kp.entry, 32'd98);
        press(2'd3, 2'd0, 4'hE, rv_at);
        chk("clr_entry", kp.entry, 32'd0);
        press(2'd2, 2'd0, 4'h7, rv_at);
        press(2'd3, 2'd2, 4'hF, rv_at);
        chk("r7_result", kp.result, 32'd7);
        chk("r7_entry", kp.entry, 32'd0);

        // Operator key between digits
        press(2'd0, 2'd0, 4'h1, rv_at);
        r0 = n_rv;
        press(2'd0, 2'd3, 4'hA, rv_at);
        chk("opA_entry", kp.entry, 32'd1);
        chk("opA_result", kp.result, 32'd7);
        chk("opA_no_rv", 32'(n_rv - r0), 32'd0);
        press(2'd0, 2'd1, 4'h2, rv_at);
        chk("e12_entry", kp.entry, 32'd12);
        press(2'd3, 2'd0, 4'hE, rv_at);

        // Reset while holding '2' with entry 42
        press(2'd1, 2'd0, 4'h4, rv_at);
        kr = 2'd0;
        kc = 2'd1;
        key_down = 1'b1;
        wait_strobe("held_strobe_seen");
        chk("held_entry", kp.entry, 32'd42);
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cols", {28'd0, kp.cols}, 32'hE);
        chk("mid_rst_strobe", {31'd0, kp.key_strobe}, 32'd0);
        chk("mid_rst_code", {28'd0, kp.key_code}, 32'd0);
        chk("mid_rst_entry", kp.entry, 32'd0);
        chk("mid_rst_count", {28'd0, kp.digit_count}, 32'd0);
        chk("mid_rst_result", kp.result, 32'd0);
        chk("mid_rst_rv", {31'd0, kp.result_valid}, 32'd0);
        rst = 1'b0;
        s0 = n_strobe;
        wait_strobe("rescan_strobe_seen");
        chk("rescan_code", {28'd0, kp.key_code}, 32'd2);
        chk("rescan_entry", kp.entry, 32'd2);
        chk("rescan_count", {28'd0, kp.digit_count}, 32'd1);
        cyc(20);
        key_down = 1'b0;
        cyc(12);
        chk("rescan_one_strobe", 32'(n_strobe - s0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces key presses, and converts typed decimal digits into a binary operand. It sits on the input side of the stopwatch-calculator top and feeds the calculator and stopwatch-preset logic. It is the inverse of the binary-to-decimal display path: decimal digits in, 32-bit binary value out. It also reports raw key codes for operator keys.

## Interface
- SCAN_DIV, 50000: clock cycles each column is driven before rows are sampled (≥2).
- DEBOUNCE, 200000: consecutive stable cycles required for press and release (≥2).
- MAX_DIGITS, 4: maximum decimal digits accumulated (1..9).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rows  in  4  keypad rows, active-low, externally pulled up, already synchronised to clk.
- cols  out  4  keypad column drive, active-low, exactly one bit low at all times.
- key_strobe  out  1  one-cycle pulse per debounced press.
- key_code  out  4  code of the last pressed key; holds between strobes.
- entry  out  32  live accumulated value, zero-extended.
- digit_count  out  4  digits currently in entry.
- result  out  32  value latched on enter.
- result_valid  out  1  one-cycle pulse when result updates.

## Operation
- Key map (row,col → key_code): r0: 1,2,3,A(0xA); r1: 4,5,6,B(0xB); r2: 7,8,9,C(0xC); r3: *(0xE),0(0x0),#(0xF),D(0xD).
- FSM states: SCAN, DEBOUNCE, HELD.
- SCAN: drive column c (cols = ~(1<<c)). A divider counts 0..SCAN_DIV-1. At count SCAN_DIV-1, sample rows:
  - rows==4'hF: c ← (c+1) mod 4, divider ← 0.
  - otherwise: capture the pattern, keep c, go to DEBOUNCE with cnt ← 0.
- If several rows are low, the lowest-index low row is the key.
- DEBOUNCE: each cycle, compare rows to the captured pattern.
  - Equal: cnt++.
  - Different: go to SCAN on the next column, divider ← 0, no strobe.
  - At cnt==DEBOUNCE-1 with equal rows: go to HELD, pulse key_strobe, load key_code, apply the key action on the same edge.
- HELD: column stays fixed. cnt counts consecutive cycles with rows==4'hF; any low row resets cnt to 0. At DEBOUNCE consecutive released cycles, go to SCAN on the next column with divider ← 0. A held key therefore produces exactly one strobe.
- Key actions, applied on the strobe edge:
  - Digit d with digit_count<MAX_DIGITS: entry ← entry*10+d, digit_count++.
  - Digit d with digit_count==MAX_DIGITS: ignored. Strobe and key_code still update.
  - '*': entry ← 0, digit_count ← 0.
  - '#': result ← entry, result_valid pulses, entry ← 0, digit_count ← 0. Applies even when digit_count==0, so result ← 0.
  - A–D: no change to entry or result.
- Arithmetic: multiply-by-10 uses (entry<<3)+(entry<<1). With MAX_DIGITS≤9, entry never exceeds 999,999,999, so no overflow handling is needed.

## Timing
- Reset values: cols=4'b1110, state SCAN, divider 0, key_code 0, key_strobe 0, entry 0, digit_count 0, result 0, result_valid 0.
- Reset mid-press clears everything. A key still held after reset is detected afresh by normal scanning.
- All outputs are registered. key_strobe, key_code, and the entry/digit_count update become visible in the same cycle. result_valid and result become visible in the same cycle.
- Press latency: let the sample edge be cycle S. The strobe is visible after edge S+DEBOUNCE.
- Minimum re-press interval: DEBOUNCE released cycles, then up to 4*SCAN_DIV cycles of scanning.
- The column wraps 3→0. The column changes only in SCAN at divider terminal count, or when leaving DEBOUNCE or HELD.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=8, MAX_DIGITS=4.
- Reset, no keys: cols cycles 1110→1101→1011→0111→1110, changing every 4 cycles; all outputs stay 0.
- Press '5' (r1,c1), held 30 cycles, then released: exactly one key_strobe, key_code=5, entry=5, digit_count=1, strobe 8 cycles after the sample edge.
- Type 1,2,3,4,5, then '#': entry=1234 after the fourth digit; the fifth digit strobes but entry stays 1234; result=1234 with a single result_valid pulse; entry=0 and digit_count=0 afterwards.
- Bounce: rows toggle low/high every 3 cycles for 20 cycles, then stay low: no strobe during bouncing; exactly one strobe once rows are stable for 8 cycles.
- '9','8','*','7','#' → result=7. 'A' between digits → key_code=0xA, entry unchanged.
- Assert rst in HELD with entry=42 → all outputs reset next cycle; with the key still held, exactly one new strobe after rescanning.
